irom_responder: RTL

//   Responder end of the instruction-fetch port: accepts word address + read enable from the fetch stage.

---
 rtl/irom_responder_pkg.sv | 17 +
 rtl/irom_responder_tag_ram.sv | 48 ++++
 rtl/irom_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/irom_responder_pkg.sv
// Shared types for the instruction-ROM responder: FSM state encoding and
// the word presented to the fetch stage while no instruction is available.
package irom_responder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Tag width left over once the word offset and line index are removed
  function automatic int tag_width(input int addr_w, input int lines, input int wpl);
    return addr_w - $clog2(lines) - $clog2(wpl);
  endfunction

endpackage

// File: rtl/irom_responder_tag_ram.sv
// Valid + tag array for the direct-mapped instruction cache.
// One lookup port, one line write (sets valid), one line invalidate and a
// single-cycle clear of every valid bit. A clear wins over a same-cycle
// write, but the tag itself is still stored.
module irom_responder_tag_ram
  import irom_responder_pkg::*;
#(
  parameter int LINES = 64,
  parameter int TAG_W = 24,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_all,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];

  // Valid bits: reset and global clear take priority over per-line updates
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (clr_all) begin
      valid <= '0;
    end else begin
      if (inv_en) valid[inv_idx] <= 1'b0;
      if (wr_en)  valid[wr_idx]  <= 1'b1;
    end
  end

  // Tag storage needs no reset; it is only trusted behind a valid bit
  always_ff @(posedge clk) begin
    if (wr_en) tags[wr_idx] <= wr_tag;
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];

endmodule

// File: rtl/irom_responder.sv
// Instruction-fetch responder: direct-mapped cache in front of a slow
// backing memory. Hits answer combinationally; a miss refills the whole
// line from its base word over the mem_req/mem_ack bus, then the lookup is
// re-evaluated.
// Build option: define IROM_Z_STALL_EN to drive rom_inst to all-Z while
// irom_fin is low; otherwise a NOP (all zeros) is driven.
module irom_responder
  import irom_responder_pkg::*;
#(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_ce,
  input  logic [ADDR_W-1:0] irom_addr,
  input  logic              inv_all,
  output logic [31:0]       rom_inst,
  output logic              irom_fin,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = tag_width(ADDR_W, LINES, WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;

  state_t           state, state_nx;
  logic [OFF_W-1:0] beat, beat_nx;
  logic [IDX_W-1:0] fill_idx, fill_idx_nx;
  logic [TAG_W-1:0] fill_tag, fill_tag_nx;
  logic             inv_pend, inv_pend_nx;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic             lookup_hit;
  logic             clr_all, tag_wr, line_inv, data_we, fin;

  logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
  logic [31:0]      hit_word;

  assign req_off = irom_addr[OFF_W-1:0];
  assign req_idx = irom_addr[OFF_W +: IDX_W];
  assign req_tag = irom_addr[ADDR_W-1 -: TAG_W];

  irom_responder_tag_ram #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_tag_ram (
    .clk      (clk),
    .rst      (rst),
    .clr_all  (clr_all),
    .wr_en    (tag_wr),
    .wr_idx   (fill_idx),
    .wr_tag   (fill_tag),
    .inv_en   (line_inv),
    .inv_idx  (req_idx),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag)
  );

  assign lookup_hit = rd_valid && (rd_tag == req_tag);

  // State register and refill bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      fill_idx <= '0;
      fill_tag <= '0;
      inv_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      beat     <= beat_nx;
      fill_idx <= fill_idx_nx;
      fill_tag <= fill_tag_nx;
      inv_pend <= inv_pend_nx;
    end
  end

  // Lookup / refill sequencing; beat wraps to 0 naturally after the last word
  always_comb begin
    state_nx    = state;
    beat_nx     = beat;
    fill_idx_nx = fill_idx;
    fill_tag_nx = fill_tag;
    inv_pend_nx = inv_pend;
    fin         = 1'b0;
    clr_all     = 1'b0;
    tag_wr      = 1'b0;
    line_inv    = 1'b0;
    data_we     = 1'b0;
    case (state)
      IDLE: begin
        if (inv_all) begin
          clr_all = 1'b1;
        end else if (read_ce) begin
          if (lookup_hit) begin
            fin = 1'b1;
          end else begin
            line_inv    = 1'b1;
            fill_idx_nx = req_idx;
            fill_tag_nx = req_tag;
            beat_nx     = '0;
            state_nx    = REFILL;
          end
        end
      end
      REFILL: begin
        if (inv_all) inv_pend_nx = 1'b1;
        if (mem_ack) begin
          data_we = 1'b1;
          beat_nx = beat + 1'b1;
          if (beat == LAST_BEAT) begin
            tag_wr      = 1'b1;
            clr_all     = inv_pend || inv_all;
            inv_pend_nx = 1'b0;
            state_nx    = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line data: single write port fed by refill beats
  always_ff @(posedge clk) begin
    if (data_we) data_mem[{fill_idx, beat}] <= mem_rdata;
  end

  assign hit_word = data_mem[{req_idx, req_off}];
  assign irom_fin = fin;
  assign mem_req  = (state == REFILL);
  assign mem_addr = {fill_tag, fill_idx, beat};

`ifdef IROM_Z_STALL_EN
  assign rom_inst = fin ? hit_word : 32'hzzzz_zzzz;
`else
  assign rom_inst = fin ? hit_word : NOP_WORD;
`endif

endmodule
